// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - EX-stage branch resolution, PC redirect, flush sequencing and branch statistics
module branch_redirect_unit #(
  parameter int WID_DATA     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic                ex_branch,
  input  logic                ex_jal,
  input  logic                ex_jalr,
  input  logic [2:0]          ex_funct3,
  input  logic [WID_DATA-1:0] ex_pc,
  input  logic [WID_DATA-1:0] ex_imm,
  input  logic [WID_DATA-1:0] rs1_data,
  input  logic                br_eq,
  input  logic                br_lt,
  input  logic                stall,
  output logic                cmpop,
  output logic                redirect_valid,
  output logic [WID_DATA-1:0] redirect_pc,
  output logic                flush,
  output logic                misalign,
  output logic                illegal_br,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    taken_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES < 4) ? 2 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state, state_d;
  logic [FCNT_W-1:0]   fcnt, fcnt_d;
  logic                redirect_valid_d, flush_d, misalign_d, illegal_br_d;
  logic [WID_DATA-1:0] redirect_pc_d;
  logic [CNT_W-1:0]    branch_cnt_d, taken_cnt_d;

  logic                br_taken, br_illegal, taken, accept;
  logic                count_branch, count_taken;
  logic [WID_DATA-1:0] add_base, sum, target;

  assign cmpop = !ex_funct3[1];

  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    case (ex_funct3)
      3'b000:         br_taken = br_eq;
      3'b001:         br_taken = !br_eq;
      3'b100, 3'b110: br_taken = br_lt;
      3'b101, 3'b111: br_taken = !br_lt;
      default:        br_illegal = 1'b1;
    endcase
  end

  // JALR clears bit 0 of its target; alignment is then judged on bit 1 alone
  assign add_base = ex_jalr ? rs1_data : ex_pc;
  assign sum      = add_base + ex_imm;
  assign target   = ex_jalr ? {sum[WID_DATA-1:1], 1'b0} : sum;

  assign taken  = ex_jal | ex_jalr | (ex_branch & br_taken);
  assign accept = ex_valid & !stall & (state == IDLE) & (ex_branch | ex_jal | ex_jalr);

  assign count_branch = accept & ex_branch & !br_illegal;
  assign count_taken  = count_branch & br_taken;

  always_comb begin
    state_d          = state;
    fcnt_d           = fcnt;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc;
    flush_d          = 1'b0;
    misalign_d       = 1'b0;
    illegal_br_d     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ex_branch && br_illegal) begin
            illegal_br_d = 1'b1;
          end else if (taken && target[1]) begin
            misalign_d = 1'b1;
          end else if (taken) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            flush_d          = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FCNT_INIT;
            end
          end
        end
      end
      FLUSH: begin
        // Wrong-path EX contents are ignored; the flush window runs out regardless of stall
        flush_d = 1'b1;
        fcnt_d  = fcnt - FCNT_LAST;
        if (fcnt == FCNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt;
    taken_cnt_d  = taken_cnt;
    if (count_branch && (branch_cnt != CNT_MAX)) begin
      branch_cnt_d = branch_cnt + CNT_ONE;
    end
    if (count_taken && (taken_cnt != CNT_MAX)) begin
      taken_cnt_d = taken_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      fcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      misalign       <= 1'b0;
      illegal_br     <= 1'b0;
      branch_cnt     <= '0;
      taken_cnt      <= '0;
    end else begin
      state          <= state_d;
      fcnt           <= fcnt_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      flush          <= flush_d;
      misalign       <= misalign_d;
      illegal_br     <= illegal_br_d;
      branch_cnt     <= branch_cnt_d;
      taken_cnt      <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - directed self-checking bench for branch_redirect_unit
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_branch, ex_jal, ex_jalr, br_eq, br_lt, stall;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, rs1_data;

  logic        cmpop, redirect_valid, flush, misalign, illegal_br;
  logic [31:0] redirect_pc, branch_cnt, taken_cnt;

  logic        s_cmpop, s_redirect_valid, s_flush, s_misalign, s_illegal_br;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_branch_cnt, s_taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_unit #(.WID_DATA(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .rs1_data(rs1_data),
    .br_eq(br_eq), .br_lt(br_lt), .stall(stall), .cmpop(cmpop), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .misalign(misalign), .illegal_br(illegal_br),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_redirect_unit #(.WID_DATA(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .rs1_data(rs1_data),
    .br_eq(br_eq), .br_lt(br_lt), .stall(stall), .cmpop(s_cmpop), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .misalign(s_misalign), .illegal_br(s_illegal_br),
    .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_funct3 = 3'b000;
    ex_pc = 0; ex_imm = 0; rs1_data = 0; br_eq = 0; br_lt = 0; stall = 0;
  endtask

  task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                            input logic eq, input logic lt);
    clear_inputs();
    ex_valid = 1; ex_branch = 1; ex_funct3 = f3; ex_pc = pc; ex_imm = imm; br_eq = eq; br_lt = lt;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%0h exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", redirect_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0h exp=0", flush); end
    checks++; if ({misalign, illegal_br} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%0h exp=0", {misalign, illegal_br}); end
    checks++; if ({branch_cnt, taken_cnt} !== 64'h0) begin errors++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", branch_cnt, taken_cnt); end
  endtask

  task automatic test_beq();
    set_branch(3'b000, 32'h100, 32'h20, 1'b1, 1'b0);
    #1;
    checks++; if (cmpop !== 1'b1) begin errors++; $display("FAIL beq_cmpop got=%0h exp=1", cmpop); end
    tick();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_rv got=%0h exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_pc got=%0h exp=120", redirect_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush1 got=%0h exp=1", flush); end
    checks++; if (branch_cnt !== 32'd1 || taken_cnt !== 32'd1) begin errors++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", branch_cnt, taken_cnt); end
    clear_inputs();
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_rv_pulse got=%0h exp=0", redirect_valid); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush2 got=%0h exp=1", flush); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_pc_hold got=%0h exp=120", redirect_pc); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_flush3 got=%0h exp=0", flush); end
  endtask

  task automatic test_cmpop();
    clear_inputs();
    ex_funct3 = 3'b100;
    #1;
    checks++; if (cmpop !== 1'b1) begin errors++; $display("FAIL blt_cmpop got=%0h exp=1", cmpop); end
    ex_funct3 = 3'b110;
    #1;
    checks++; if (cmpop !== 1'b0) begin errors++; $display("FAIL bltu_cmpop got=%0h exp=0", cmpop); end
    set_branch(3'b111, 32'h300, 32'h80, 1'b0, 1'b1);
    tick();
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL bgeu_nt got=%0h/%0h exp=0/0", redirect_valid, flush); end
    checks++; if (branch_cnt !== 32'd2 || taken_cnt !== 32'd1) begin errors++; $display("FAIL bgeu_cnt got=%0d/%0d exp=2/1", branch_cnt, taken_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_jalr();
    clear_inputs();
    ex_valid = 1; ex_jalr = 1; rs1_data = 32'h1003; ex_imm = 32'h2; ex_pc = 32'h80;
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004) begin errors++; $display("FAIL jalr_pc got=%0h/%0h exp=1/1004", redirect_valid, redirect_pc); end
    checks++; if (branch_cnt !== 32'd2 || taken_cnt !== 32'd1) begin errors++; $display("FAIL jalr_nocnt got=%0d/%0d exp=2/1", branch_cnt, taken_cnt); end
    clear_inputs();
    tick();
    tick();
    ex_valid = 1; ex_jalr = 1; rs1_data = 32'h1001; ex_imm = 32'h1;
    tick();
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL jalr_misalign got=%0h exp=1", misalign); end
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL jalr_mis_noredir got=%0h/%0h exp=0/0", redirect_valid, flush); end
    checks++; if (redirect_pc !== 32'h1004) begin errors++; $display("FAIL jalr_mis_pc_hold got=%0h exp=1004", redirect_pc); end
    clear_inputs();
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jalr_mis_pulse got=%0h exp=0", misalign); end
  endtask

  task automatic test_stall();
    set_branch(3'b001, 32'h200, 32'h40, 1'b0, 1'b0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL stall_quiet%0d got=%0h/%0h exp=0/0", i, redirect_valid, flush); end
    end
    stall = 0;
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin errors++; $display("FAIL bne_redir got=%0h/%0h exp=1/240", redirect_valid, redirect_pc); end
    checks++; if (branch_cnt !== 32'd3 || taken_cnt !== 32'd2) begin errors++; $display("FAIL bne_cnt got=%0d/%0d exp=3/2", branch_cnt, taken_cnt); end
    set_branch(3'b000, 32'h300, 32'h8, 1'b1, 1'b0);
    tick();
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h240 || flush !== 1'b1) begin errors++; $display("FAIL flush_ignore got=%0h/%0h/%0h exp=0/240/1", redirect_valid, redirect_pc, flush); end
    checks++; if (branch_cnt !== 32'd3 || taken_cnt !== 32'd2) begin errors++; $display("FAIL flush_nocnt got=%0d/%0d exp=3/2", branch_cnt, taken_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_illegal();
    set_branch(3'b011, 32'h400, 32'h10, 1'b1, 1'b1);
    tick();
    checks++; if (illegal_br !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%0h exp=1", illegal_br); end
    checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL illegal_noredir got=%0h/%0h exp=0/0", redirect_valid, flush); end
    checks++; if (branch_cnt !== 32'd3 || taken_cnt !== 32'd2) begin errors++; $display("FAIL illegal_nocnt got=%0d/%0d exp=3/2", branch_cnt, taken_cnt); end
    clear_inputs();
    tick();
    checks++; if (illegal_br !== 1'b0) begin errors++; $display("FAIL illegal_single got=%0h exp=0", illegal_br); end
  endtask

  task automatic test_reset_flush();
    set_branch(3'b000, 32'h600, 32'h20, 1'b1, 1'b0);
    tick();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rstf_pre got=%0h exp=1", redirect_valid); end
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if ({redirect_valid, flush, misalign, illegal_br} !== 4'b0000) begin errors++; $display("FAIL rstf_outs got=%0h exp=0", {redirect_valid, flush, misalign, illegal_br}); end
    checks++; if (redirect_pc !== 32'h0 || branch_cnt !== 32'h0 || taken_cnt !== 32'h0) begin errors++; $display("FAIL rstf_regs got=%0h/%0h/%0h exp=0/0/0", redirect_pc, branch_cnt, taken_cnt); end
    set_branch(3'b000, 32'h40, 32'h10, 1'b1, 1'b0);
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h50 || branch_cnt !== 32'd1) begin errors++; $display("FAIL rstf_idle got=%0h/%0h/%0d exp=1/50/1", redirect_valid, redirect_pc, branch_cnt); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ex_valid = 1; ex_jal = 1; ex_pc = 32'h500; ex_imm = 32'h100;
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600) begin errors++; $display("FAIL b2b_a got=%0h/%0h exp=1/600", redirect_valid, redirect_pc); end
    clear_inputs();
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush got=%0h exp=1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush_end got=%0h exp=0", flush); end
    ex_valid = 1; ex_jal = 1; ex_pc = 32'h700; ex_imm = 32'h10;
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h710 || flush !== 1'b1) begin errors++; $display("FAIL b2b_b got=%0h/%0h/%0h exp=1/710/1", redirect_valid, redirect_pc, flush); end
    checks++; if (branch_cnt !== 32'd1 || taken_cnt !== 32'd1) begin errors++; $display("FAIL b2b_jal_nocnt got=%0d/%0d exp=1/1", branch_cnt, taken_cnt); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_branch(3'b000, 32'h1000, 32'h8, 1'b1, 1'b0);
      tick();
      clear_inputs();
      tick();
      tick();
    end
    checks++; if (s_branch_cnt !== 4'hF || s_taken_cnt !== 4'hF) begin errors++; $display("FAIL sat_small got=%0h/%0h exp=f/f", s_branch_cnt, s_taken_cnt); end
    checks++; if (branch_cnt !== 32'd17 || taken_cnt !== 32'd17) begin errors++; $display("FAIL sat_wide got=%0d/%0d exp=17/17", branch_cnt, taken_cnt); end
    set_branch(3'b000, 32'h1000, 32'h8, 1'b0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++; if (s_branch_cnt !== 4'hF || s_taken_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0h/%0h exp=f/f", s_branch_cnt, s_taken_cnt); end
    checks++; if (branch_cnt !== 32'd18 || taken_cnt !== 32'd17) begin errors++; $display("FAIL sat_wide_nt got=%0d/%0d exp=18/17", branch_cnt, taken_cnt); end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #1;
    test_reset();
    test_beq();
    test_cmpop();
    test_jalr();
    test_stall();
    test_illegal();
    test_reset_flush();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
